// File: rtl/mad_int_pkg.sv
// ============================================================================
// Module   : mad_int_pkg
// Brief    : Shared FSM encoding, default parameters and the channel-index
//            width helper for the mad_int_ctrl interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mad_int_pkg;

    localparam int              c_NUM_CH_DEF   = 4;
    localparam int              c_VEC_W_DEF    = 16;
    localparam logic [15:0]     c_VEC_BASE_DEF = 16'h0000;

    localparam logic [1:0]      c_ST_IDLE      = 2'd0;
    localparam logic [1:0]      c_ST_REQ       = 2'd1;
    localparam logic [1:0]      c_ST_SERVICE   = 2'd2;

    // A single channel still needs a one-bit index.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mad_prio_enc.sv
// ============================================================================
// Module   : mad_prio_enc
// Brief    : Combinational lowest-index-wins priority encoder with valid flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mad_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic [ID_W-1:0]   o_idx,
    output logic              o_valid
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = ID_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mad_int_ctrl.sv
// ============================================================================
// Module   : mad_int_ctrl
// Brief    : Fixed-priority vectored interrupt controller with mask register
//            and IDLE/REQ/SERVICE handshake. Define MAD_INT_EDGE_EN for
//            rising-edge capture; otherwise inputs are level sampled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

import mad_int_pkg::*;

module mad_int_ctrl #(
    parameter int               NUM_CH   = c_NUM_CH_DEF,
    parameter int               VEC_W    = c_VEC_W_DEF,
    parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(c_VEC_BASE_DEF),
    localparam int              c_ID_W   = id_w(NUM_CH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NUM_CH-1:0] IntIn,
    input  logic              MaskWe,
    input  logic [NUM_CH-1:0] MaskIn,
    output logic [NUM_CH-1:0] MaskOut,
    output logic [NUM_CH-1:0] Pending,
    output logic              IntReq,
    input  logic              IntAck,
    output logic [c_ID_W-1:0] IntId,
    output logic [VEC_W-1:0]  IntVec,
    input  logic              IntDone,
    output logic              Busy
);

    logic [1:0]        r_state;
    logic [c_ID_W-1:0] r_id;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_elig;
    logic [c_ID_W-1:0] w_win_idx;
    logic              w_win_valid;
    logic [VEC_W-1:0]  w_id_ext;

    assign w_elig = r_pend & ~r_mask;

    mad_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (c_ID_W)
    ) u_prio_enc (
        .i_req   (w_elig),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mask <= '0;
        end else if (MaskWe) begin
            r_mask <= MaskIn;
        end
    end

`ifdef MAD_INT_EDGE_EN
    logic [NUM_CH-1:0] r_hist;
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_clr;

    assign w_evt = IntIn & ~r_hist;
    assign w_clr = (r_state == c_ST_REQ && IntAck) ? (NUM_CH'(1) << r_id) : '0;

    // A fresh edge on the channel being acknowledged wins over the clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_hist <= '0;
            r_pend <= '0;
        end else begin
            r_hist <= IntIn;
            r_pend <= (r_pend & ~w_clr) | w_evt;
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= IntIn;
        end
    end
`endif

    // Once latched in REQ the grant is held until acknowledged, regardless of
    // later mask or pending changes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_ST_IDLE;
            r_id    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_win_valid) begin
                        r_id    <= w_win_idx;
                        r_state <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (IntAck) r_state <= c_ST_SERVICE;
                end
                c_ST_SERVICE: begin
                    if (IntDone) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_id_ext = VEC_W'(r_id);

    assign MaskOut = r_mask;
    assign Pending = r_pend;
    assign IntReq  = (r_state == c_ST_REQ);
    assign Busy    = (r_state == c_ST_SERVICE);
    assign IntId   = r_id;
    assign IntVec  = VEC_BASE + (w_id_ext << 1);

endmodule

`default_nettype wire

// File: tb/tb_mad_int_ctrl.sv
// ============================================================================
// Module   : tb_mad_int_ctrl
// Brief    : Scoreboard bench for mad_int_ctrl (NUM_CH=4), with a second
//            instance at VEC_BASE=16'hFFFE to exercise vector wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mad_int_ctrl;

    typedef enum int {M_IDLE, M_REQ, M_SVC} mode_t;

    typedef struct {
        logic        req;
        logic        busy;
        logic        idv;
        logic [1:0]  id;
        logic [15:0] vec;
        logic [15:0] vecw;
        logic [3:0]  pend;
        logic [3:0]  mask;
    } exp_t;

    logic        Clk;
    logic        Rst;
    logic [3:0]  IntIn;
    logic        MaskWe;
    logic [3:0]  MaskIn;
    logic        IntAck;
    logic        IntDone;
    logic [3:0]  MaskOut, Pending;
    logic        IntReq, Busy;
    logic [1:0]  IntId;
    logic [15:0] IntVec;
    logic [3:0]  w_mask2, w_pend2;
    logic        w_req2, w_busy2;
    logic [1:0]  w_id2;
    logic [15:0] w_vec2;

    mad_int_ctrl #(.NUM_CH(4), .VEC_W(16), .VEC_BASE(16'h0000)) u_dut (
        .Clk(Clk), .Rst(Rst), .IntIn(IntIn), .MaskWe(MaskWe), .MaskIn(MaskIn),
        .MaskOut(MaskOut), .Pending(Pending), .IntReq(IntReq), .IntAck(IntAck),
        .IntId(IntId), .IntVec(IntVec), .IntDone(IntDone), .Busy(Busy)
    );

    mad_int_ctrl #(.NUM_CH(4), .VEC_W(16), .VEC_BASE(16'hFFFE)) u_dut_wrap (
        .Clk(Clk), .Rst(Rst), .IntIn(IntIn), .MaskWe(MaskWe), .MaskIn(MaskIn),
        .MaskOut(w_mask2), .Pending(w_pend2), .IntReq(w_req2), .IntAck(IntAck),
        .IntId(w_id2), .IntVec(w_vec2), .IntDone(IntDone), .Busy(w_busy2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int    total = 0;
    int    bad   = 0;
    bit    drv_done = 1'b0;
    exp_t  sb_q[$];

    // Reference model state
    mode_t m_mode = M_IDLE;
    int    m_id   = 0;
    bit    m_pend[4];
    bit    m_mask[4];
    bit    m_hist[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs (called just after a falling edge) and push
    // what the outputs must look like after the coming rising edge.
    task automatic drive(input bit rst, input logic [3:0] in, input bit we,
                         input logic [3:0] min, input bit ack, input bit done);
        exp_t e;
        int   winner;
        Rst = rst; IntIn = in; MaskWe = we; MaskIn = min; IntAck = ack; IntDone = done;
        if (rst) begin
            m_mode = M_IDLE;
            m_id   = 0;
            foreach (m_pend[i]) begin m_pend[i] = 0; m_mask[i] = 0; m_hist[i] = 0; end
        end else begin
            winner = -1;
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && !m_mask[i]) winner = i;
`ifdef MAD_INT_EDGE_EN
            if (m_mode == M_REQ && ack) m_pend[m_id] = 0;
            for (int i = 0; i < 4; i++) begin
                if (in[i] && !m_hist[i]) m_pend[i] = 1;
                m_hist[i] = in[i];
            end
`else
            for (int i = 0; i < 4; i++) m_pend[i] = in[i];
`endif
            if (we) for (int i = 0; i < 4; i++) m_mask[i] = min[i];
            case (m_mode)
                M_IDLE: if (winner >= 0) begin m_mode = M_REQ; m_id = winner; end
                M_REQ:  if (ack) m_mode = M_SVC;
                M_SVC:  if (done) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
        e.req  = (m_mode == M_REQ);
        e.busy = (m_mode == M_SVC);
        e.idv  = (m_mode != M_IDLE) || rst;
        e.id   = 2'(m_id);
        e.vec  = 16'(2 * m_id);
        e.vecw = 16'(32'hFFFE + 2 * m_id);
        for (int i = 0; i < 4; i++) begin e.pend[i] = m_pend[i]; e.mask[i] = m_mask[i]; end
        sb_q.push_back(e);
    endtask

    // Monitor: every rising edge the DUT presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("IntReq",  32'(IntReq),  32'(e.req));
                chk("Busy",    32'(Busy),    32'(e.busy));
                chk("Pending", 32'(Pending), 32'(e.pend));
                chk("MaskOut", 32'(MaskOut), 32'(e.mask));
                if (e.idv) begin
                    chk("IntId",      32'(IntId),  32'(e.id));
                    chk("IntVec",     32'(IntVec), 32'(e.vec));
                    chk("IntVecWrap", 32'(w_vec2), 32'(e.vecw));
                end
            end
        end
    end

    initial begin
        Rst = 1'b1; IntIn = '0; MaskWe = 1'b0; MaskIn = '0; IntAck = 1'b0; IntDone = 1'b0;
        @(negedge Clk);
        drive(1, 4'b0000, 0, 4'b0000, 0, 0);
        // single source, then two simultaneous sources
        @(negedge Clk); drive(0, 4'b0100, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0100, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0100, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b1010, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b1010, 0, 4'b0000, 0, 1);
        @(negedge Clk); drive(0, 4'b1010, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b1010, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b1000, 0, 4'b0000, 0, 1);
        @(negedge Clk); drive(0, 4'b1000, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0000, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b0000, 0, 4'b0000, 0, 1);
        // masked channel stays pending, unmask releases it
        @(negedge Clk); drive(0, 4'b0000, 1, 4'b0001, 0, 0);
        @(negedge Clk); drive(0, 4'b0001, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0001, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0001, 1, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0001, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b1000, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b1000, 0, 4'b0000, 0, 0);
        // reset while in service with a pending channel
        @(negedge Clk); drive(1, 4'b1000, 1, 4'b1111, 1, 1);
        @(negedge Clk); drive(0, 4'b0000, 0, 4'b0000, 0, 0);
        // level-held source reasserting across ack/done
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 1, 0);
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 0, 1);
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 0, 0);
        @(negedge Clk); drive(0, 4'b0010, 0, 4'b0000, 0, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit         r_rst, r_we, r_ack, r_done;
            logic [3:0] r_in, r_min;
            r_rst  = ($urandom_range(0, 79) == 0);
            r_in   = 4'($urandom) & 4'($urandom);
            r_we   = ($urandom_range(0, 9) == 0);
            r_min  = 4'($urandom) & 4'($urandom);
            r_ack  = (m_mode == M_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            r_done = (m_mode == M_SVC) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            @(negedge Clk);
            drive(r_rst, r_in, r_we, r_min, r_ack, r_done);
        end
        @(negedge Clk);
        Rst = 1'b0; IntAck = 1'b0; IntDone = 1'b0; MaskWe = 1'b0;
        @(posedge Clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d expected=0 entries left", sb_q.size());
        end
        drv_done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
